// File: rtl/load_store_controller_pkg.sv
// Shared opcode, ALU and state encodings for the load/store controller and its datapath.
package load_store_controller_pkg;

  localparam logic [5:0] LSC_OP_LW   = 6'b100011;
  localparam logic [5:0] LSC_OP_SW   = 6'b101011;
  localparam logic [3:0] LSC_ALU_ADD = 4'b0010;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

endpackage

// File: rtl/load_store_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones. Single-cycle update, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/load_store_controller.sv
// Multi-cycle lw/sw sequencer: done 4 cycles after accept for lw, 3 for sw.
// Backpressure: instr_ready is high only in IDLE; the driver holds instr_valid until then.
module load_store_controller
  import load_store_controller_pkg::*;
#(
  parameter int         N       = 32,
  parameter int         CNT_W   = 16,
  parameter logic [5:0] OP_LW   = LSC_OP_LW,
  parameter logic [5:0] OP_SW   = LSC_OP_SW,
  parameter logic [3:0] ALU_ADD = LSC_ALU_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [N-1:0]     instruction,
  output logic [3:0]       ALU_OP,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] lw_count,
  output logic [CNT_W-1:0] sw_count
);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [N-1:0] ir;
  logic         is_lw;
  logic         is_sw;
  logic         lw_retire;
  logic         sw_retire;

  assign is_lw = (ir[31:26] == OP_LW);
  assign is_sw = (ir[31:26] == OP_SW);

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = instr_valid ? S_DECODE : S_IDLE;
      S_DECODE: state_nxt = (is_lw || is_sw) ? S_ADDR : S_IDLE;
      S_ADDR:   state_nxt = S_MEM;
      S_MEM:    state_nxt = is_lw ? S_WB : S_IDLE;
      S_WB:     state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && instr_valid)
        ir <= instr_in;
    end
  end

  // ALU keeps adding through WB so the memory address stays valid while the load data is written back.
  assign ALU_OP      = (state == S_DECODE || state == S_ADDR || state == S_MEM || state == S_WB)
                       ? ALU_ADD : 4'b0000;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign instruction = ir;

  assign lw_retire = ~rst & (state == S_WB);
  assign sw_retire = ~rst & (state == S_MEM) & is_sw;

  assign MemRead  = ~rst & (((state == S_MEM) & is_lw) | (state == S_WB));
  assign MemWrite = sw_retire;
  assign RegWrite = lw_retire;
  assign done     = lw_retire | sw_retire;
  assign illegal  = ~rst & (state == S_DECODE) & ~(is_lw | is_sw);

  sat_counter #(.W(CNT_W)) u_lw_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lw_retire),
    .count (lw_count)
  );

  sat_counter #(.W(CNT_W)) u_sw_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sw_retire),
    .count (sw_count)
  );

endmodule
